// File: rtl/multi_cycle_control_if.sv
// Control bundle between the multi-cycle sequencer and its datapath.
//   instruction : IR contents (Format [31:26], Funct [5:0])
//   mem_ready   : memory handshake, completes an access while MemRd/MemWr is high
//   irq, kernel : level interrupt request and PC[31] (masks irq when high)
//   state       : current sequencer state
//   IorD .. ALUSrcB : datapath selects and write/read strobes
// master: the sequencer (drives control, samples status).
// slave : the datapath side (drives status, samples control).
interface multi_cycle_control_if;
    logic [31:0] instruction;
    logic        mem_ready;
    logic        irq;
    logic        kernel;

    logic [2:0]  state;
    logic        IorD;
    logic        IRWr;
    logic        PCWr;
    logic        PCWrCond;
    logic        RegWr;
    logic        MemRd;
    logic        MemWr;
    logic [2:0]  PCSrc;
    logic [1:0]  RegDst;
    logic [1:0]  MemToReg;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;

    modport master (
        input  instruction, mem_ready, irq, kernel,
        output state, IorD, IRWr, PCWr, PCWrCond, RegWr, MemRd, MemWr,
               PCSrc, RegDst, MemToReg, ALUSrcA, ALUSrcB
    );

    modport slave (
        output instruction, mem_ready, irq, kernel,
        input  state, IorD, IRWr, PCWr, PCWrCond, RegWr, MemRd, MemWr,
               PCSrc, RegDst, MemToReg, ALUSrcA, ALUSrcB
    );
endinterface

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-subset control sequencer.
// States FETCH, DECODE, EXEC, MEM, WB, TRAP. Memory accesses wait on mem_ready and
// abort to TRAP (XADR) after MEM_WAIT_MAX stalled cycles. An unmasked irq seen on the
// first FETCH cycle traps with cause ILLOP instead of fetching.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset; forces every output to 0
//   bus   : control bundle (master modport), see multi_cycle_control_if
module multi_cycle_control #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input logic                    clk,
    input logic                    reset,
    multi_cycle_control_if.master  bus
);

    localparam logic [2:0] StFetch  = 3'd0;
    localparam logic [2:0] StDecode = 3'd1;
    localparam logic [2:0] StExec   = 3'd2;
    localparam logic [2:0] StMem    = 3'd3;
    localparam logic [2:0] StWb     = 3'd4;
    localparam logic [2:0] StTrap   = 3'd5;

    localparam logic CauseIllop = 1'b0;
    localparam logic CauseXadr  = 1'b1;

    localparam logic [3:0] ClsIll  = 4'd0;
    localparam logic [3:0] ClsRalu = 4'd1;
    localparam logic [3:0] ClsIalu = 4'd2;
    localparam logic [3:0] ClsBr   = 4'd3;
    localparam logic [3:0] ClsLw   = 4'd4;
    localparam logic [3:0] ClsSw   = 4'd5;
    localparam logic [3:0] ClsJ    = 4'd6;
    localparam logic [3:0] ClsJal  = 4'd7;
    localparam logic [3:0] ClsJr   = 4'd8;
    localparam logic [3:0] ClsJalr = 4'd9;

    localparam logic [7:0] WaitMax = 8'(MEM_WAIT_MAX);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       cause_q, cause_d;

    logic [5:0] op, fn;
    logic [3:0] cls;
    logic       fetch_entry, timeout;
    logic       unused_instr;

    logic       iord_c, irwr_c, pcwr_c, pcwc_c, regwr_c, memrd_c, memwr_c, asa_c;
    logic [2:0] pcsrc_c;
    logic [1:0] regdst_c, m2r_c, asb_c;

    assign op = bus.instruction[31:26];
    assign fn = bus.instruction[5:0];
    assign unused_instr = ^bus.instruction[25:6];

    // The counter only ever reads 0 in FETCH on the cycle the state was entered (it
    // clears on every state change and FETCH is never re-entered from itself), so a
    // zero count marks the entry cycle.
    assign fetch_entry = (state_q == StFetch) && (cnt_q == 8'd0);
    assign timeout     = (cnt_q == WaitMax) && !bus.mem_ready;

    always_comb begin
        cls = ClsIll;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h00, 6'h02, 6'h03, 6'h2A: cls = ClsRalu;
                    6'h08:                      cls = ClsJr;
                    6'h09:                      cls = ClsJalr;
                    default:                    cls = ClsIll;
                endcase
            end
            6'h01, 6'h04, 6'h05, 6'h06, 6'h07:         cls = ClsBr;
            6'h02:                                     cls = ClsJ;
            6'h03:                                     cls = ClsJal;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0F:  cls = ClsIalu;
            6'h23:                                     cls = ClsLw;
            6'h2B:                                     cls = ClsSw;
            default:                                   cls = ClsIll;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        iord_c   = 1'b0;
        irwr_c   = 1'b0;
        pcwr_c   = 1'b0;
        pcwc_c   = 1'b0;
        regwr_c  = 1'b0;
        memrd_c  = 1'b0;
        memwr_c  = 1'b0;
        asa_c    = 1'b0;
        pcsrc_c  = 3'b000;
        regdst_c = 2'b00;
        m2r_c    = 2'b00;
        asb_c    = 2'b00;

        case (state_q)
            StFetch: begin
                if (fetch_entry && bus.irq && !bus.kernel) begin
                    state_d = StTrap;
                    cause_d = CauseIllop;
                end else begin
                    asb_c = 2'b01;
                    // Completion takes priority over a timeout in the same cycle.
                    if (bus.mem_ready) begin
                        memrd_c = 1'b1;
                        irwr_c  = 1'b1;
                        pcwr_c  = 1'b1;
                        state_d = StDecode;
                    end else if (timeout) begin
                        state_d = StTrap;
                        cause_d = CauseXadr;
                    end else begin
                        memrd_c = 1'b1;
                    end
                end
            end

            StDecode: begin
                asb_c = 2'b11;
                case (cls)
                    ClsIll: begin
                        state_d = StTrap;
                        cause_d = CauseXadr;
                    end
                    ClsJ, ClsJal: begin
                        pcwr_c  = 1'b1;
                        pcsrc_c = 3'b010;
                        state_d = StFetch;
                        if (cls == ClsJal) begin
                            regwr_c  = 1'b1;
                            regdst_c = 2'b10;
                            m2r_c    = 2'b10;
                        end
                    end
                    ClsJr, ClsJalr: begin
                        pcwr_c  = 1'b1;
                        pcsrc_c = 3'b011;
                        state_d = StFetch;
                        if (cls == ClsJalr) begin
                            regwr_c  = 1'b1;
                            regdst_c = 2'b10;
                            m2r_c    = 2'b10;
                        end
                    end
                    default: state_d = StExec;
                endcase
            end

            StExec: begin
                asa_c = 1'b1;
                case (cls)
                    ClsBr: begin
                        pcwc_c  = 1'b1;
                        pcsrc_c = 3'b001;
                        state_d = StFetch;
                    end
                    ClsLw, ClsSw: begin
                        asb_c   = 2'b10;
                        state_d = StMem;
                    end
                    ClsIalu: begin
                        asb_c   = 2'b10;
                        state_d = StWb;
                    end
                    ClsRalu: state_d = StWb;
                    default: state_d = StFetch;
                endcase
            end

            StMem: begin
                iord_c = 1'b1;
                if (cls != ClsLw && cls != ClsSw) begin
                    state_d = StFetch;
                end else if (bus.mem_ready) begin
                    memrd_c = (cls == ClsLw);
                    memwr_c = (cls == ClsSw);
                    state_d = (cls == ClsLw) ? StWb : StFetch;
                end else if (timeout) begin
                    state_d = StTrap;
                    cause_d = CauseXadr;
                end else begin
                    memrd_c = (cls == ClsLw);
                    memwr_c = (cls == ClsSw);
                end
            end

            StWb: begin
                regwr_c = 1'b1;
                state_d = StFetch;
                case (cls)
                    ClsIalu: regdst_c = 2'b01;
                    ClsLw: begin
                        regdst_c = 2'b01;
                        m2r_c    = 2'b01;
                    end
                    default: regdst_c = 2'b00;
                endcase
            end

            StTrap: begin
                regwr_c  = 1'b1;
                pcwr_c   = 1'b1;
                regdst_c = 2'b11;
                m2r_c    = 2'b10;
                pcsrc_c  = (cause_q == CauseXadr) ? 3'b101 : 3'b100;
                state_d  = StFetch;
            end

            default: state_d = StFetch;
        endcase
    end

    always_comb begin
        if (state_d != state_q) begin
            cnt_d = 8'd0;
        end else if ((state_q == StFetch || state_q == StMem) && !bus.mem_ready &&
                     cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
            cnt_q   <= 8'd0;
            cause_q <= CauseIllop;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Outputs are gated by reset combinationally so an access in flight drops at once.
    always_comb begin
        bus.state    = state_q;
        bus.IorD     = reset & iord_c;
        bus.IRWr     = reset & irwr_c;
        bus.PCWr     = reset & pcwr_c;
        bus.PCWrCond = reset & pcwc_c;
        bus.RegWr    = reset & regwr_c;
        bus.MemRd    = reset & memrd_c;
        bus.MemWr    = reset & memwr_c;
        bus.ALUSrcA  = reset & asa_c;
        bus.PCSrc    = reset ? pcsrc_c  : 3'b000;
        bus.RegDst   = reset ? regdst_c : 2'b00;
        bus.MemToReg = reset ? m2r_c    : 2'b00;
        bus.ALUSrcB  = reset ? asb_c    : 2'b00;
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
module tb_multi_cycle_control;

    localparam int WAIT_MAX = 15;

    localparam int K_ILL = 0, K_RALU = 1, K_IALU = 2, K_BR = 3, K_LW = 4, K_SW = 5,
                   K_J = 6, K_JAL = 7, K_JR = 8, K_JALR = 9;

    // Strobe vector order: IRWr, PCWr, PCWrCond, RegWr, MemRd, MemWr
    localparam logic [5:0] B_IRWR = 6'b100000, B_PCWR = 6'b010000, B_PCWC = 6'b001000,
                           B_REGWR = 6'b000100, B_MEMRD = 6'b000010, B_MEMWR = 6'b000001,
                           B_NONE = 6'b000000;

    // Packed output: state[19:17] IorD[16] strobes[15:10] PCSrc[9:7] RegDst[6:5]
    // MemToReg[4:3] ALUSrcA[2] ALUSrcB[1:0]
    localparam logic [19:0] M_BASE = 20'hEFC00, M_IORD = 20'h10000, M_PCSRC = 20'h00380,
                            M_RD = 20'h00060, M_M2R = 20'h00018, M_ASA = 20'h00004,
                            M_ASB = 20'h00003, M_ALL = 20'hFFFFF;

    typedef struct {
        logic [31:0] instr;
        bit          rdy;
        bit          irq;
        bit          kern;
        logic [19:0] exp;
        logic [19:0] care;
        string       tag;
    } rec_t;

    typedef struct {
        logic [19:0] exp;
        logic [19:0] care;
        string       tag;
    } chk_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    multi_cycle_control_if bus ();

    multi_cycle_control #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    rec_t plan[$];
    chk_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [11:0] legal [29] = '{
        {6'h00, 6'h20}, {6'h00, 6'h21}, {6'h00, 6'h22}, {6'h00, 6'h23}, {6'h00, 6'h24},
        {6'h00, 6'h25}, {6'h00, 6'h26}, {6'h00, 6'h27}, {6'h00, 6'h00}, {6'h00, 6'h02},
        {6'h00, 6'h03}, {6'h00, 6'h2A}, {6'h00, 6'h08}, {6'h00, 6'h09},
        {6'h23, 6'h00}, {6'h2B, 6'h00}, {6'h0F, 6'h00}, {6'h08, 6'h00}, {6'h09, 6'h00},
        {6'h0C, 6'h00}, {6'h0A, 6'h00}, {6'h0B, 6'h00}, {6'h04, 6'h00}, {6'h05, 6'h00},
        {6'h06, 6'h00}, {6'h07, 6'h00}, {6'h01, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00}
    };

    function automatic int klass(logic [31:0] ins);
        logic [5:0] op = ins[31:26];
        logic [5:0] fn = ins[5:0];
        case (op)
            6'h00: begin
                if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h00, 6'h02, 6'h03, 6'h2A}) return K_RALU;
                if (fn == 6'h08) return K_JR;
                if (fn == 6'h09) return K_JALR;
                return K_ILL;
            end
            6'h01, 6'h04, 6'h05, 6'h06, 6'h07:        return K_BR;
            6'h02:                                    return K_J;
            6'h03:                                    return K_JAL;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0F: return K_IALU;
            6'h23:                                    return K_LW;
            6'h2B:                                    return K_SW;
            default:                                  return K_ILL;
        endcase
    endfunction

    function automatic logic [19:0] ev(logic [2:0] st, logic iord, logic [5:0] strb,
                                       logic [2:0] pcs, logic [1:0] rd, logic [1:0] m2r,
                                       logic asa, logic [1:0] asb);
        return {st, iord, strb, pcs, rd, m2r, asa, asb};
    endfunction

    function automatic logic [19:0] pack_out();
        return {bus.state, bus.IorD, bus.IRWr, bus.PCWr, bus.PCWrCond, bus.RegWr,
                bus.MemRd, bus.MemWr, bus.PCSrc, bus.RegDst, bus.MemToReg,
                bus.ALUSrcA, bus.ALUSrcB};
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(string tag, logic [19:0] got, logic [19:0] want, logic [19:0] care);
        n_cmp++;
        if (((got ^ want) & care) != 20'h0) begin
            n_bad++;
            $display("FAIL %s @%0t: got %05h required %05h (mask %05h)",
                     tag, $time, got, want, care);
        end
    endtask

    task automatic add(logic [31:0] ins, bit rdy, bit irq, bit kern, logic [19:0] exp,
                       logic [19:0] care, string tag);
        rec_t r;
        r.instr = ins; r.rdy = rdy; r.irq = irq; r.kern = kern;
        r.exp = exp; r.care = care; r.tag = tag;
        plan.push_back(r);
    endtask

    task automatic plan_trap(logic [31:0] ins, bit xadr, string tag);
        add(ins, rb(), rb(), rb(),
            ev(3'd5, 1'b0, B_REGWR | B_PCWR, xadr ? 3'b101 : 3'b100, 2'b11, 2'b10, 1'b0, 2'b00),
            M_BASE | M_PCSRC | M_RD | M_M2R, tag);
    endtask

    // One memory access (instruction fetch or data access) stalled wait_n cycles.
    task automatic plan_access(logic [31:0] ins, bit is_fetch, bit is_lw, int wait_n,
                               bit irq0, bit kern0, output bit ok);
        logic [2:0]  st   = is_fetch ? 3'd0 : 3'd3;
        logic [5:0]  strb = (is_fetch || is_lw) ? B_MEMRD : B_MEMWR;
        logic [19:0] care = is_fetch ? (M_BASE | M_IORD | M_PCSRC | M_ASA | M_ASB)
                                     : (M_BASE | M_IORD);
        logic [1:0]  asb  = is_fetch ? 2'b01 : 2'b00;
        bit irq, kern;
        ok = 1'b0;
        for (int i = 0; i <= WAIT_MAX; i++) begin
            irq  = (i == 0) ? irq0 : rb();
            kern = (i == 0) ? kern0 : rb();
            if (i == wait_n) begin
                add(ins, 1'b1, irq, kern,
                    ev(st, !is_fetch, is_fetch ? (strb | B_IRWR | B_PCWR) : strb,
                       3'b000, 2'b00, 2'b00, 1'b0, asb), care,
                    is_fetch ? "fetch_done" : "mem_done");
                ok = 1'b1;
                return;
            end
            if (i == WAIT_MAX) begin
                add(ins, 1'b0, irq, kern, ev(st, !is_fetch, B_NONE, 3'b000, 2'b00, 2'b00,
                    1'b0, asb), M_BASE, is_fetch ? "fetch_timeout" : "mem_timeout");
                plan_trap(ins, 1'b1, "trap_timeout");
                return;
            end
            add(ins, 1'b0, irq, kern, ev(st, !is_fetch, strb, 3'b000, 2'b00, 2'b00, 1'b0, asb),
                care, is_fetch ? "fetch_wait" : "mem_wait");
        end
    endtask

    task automatic plan_wb(logic [31:0] ins, logic [1:0] rd, logic [1:0] m2r);
        add(ins, rb(), rb(), rb(), ev(3'd4, 1'b0, B_REGWR, 3'b000, rd, m2r, 1'b0, 2'b00),
            M_BASE | M_RD | M_M2R, "wb");
    endtask

    // Whole-instruction reference: the cycle-by-cycle outputs one instruction must show.
    task automatic plan_instr(logic [31:0] ins, bit irq0, bit kern0, int wf, int wm);
        int k = klass(ins);
        bit ok;
        logic [19:0] dcare = M_BASE | M_ASA | M_ASB;
        if (irq0 && !kern0) begin
            add(ins, rb(), 1'b1, 1'b0, ev(3'd0, 1'b0, B_NONE, 3'b000, 2'b00, 2'b00, 1'b0,
                2'b00), M_BASE, "fetch_irq");
            plan_trap(ins, 1'b0, "trap_illop");
            return;
        end
        plan_access(ins, 1'b1, 1'b0, wf, irq0, kern0, ok);
        if (!ok) return;
        case (k)
            K_ILL: begin
                add(ins, rb(), rb(), rb(), ev(3'd1, 1'b0, B_NONE, 3'b000, 2'b00, 2'b00, 1'b0,
                    2'b11), dcare, "decode_ill");
                plan_trap(ins, 1'b1, "trap_xadr");
                return;
            end
            K_J, K_JR:
                add(ins, rb(), rb(), rb(), ev(3'd1, 1'b0, B_PCWR, (k == K_J) ? 3'b010 : 3'b011,
                    2'b00, 2'b00, 1'b0, 2'b11), dcare | M_PCSRC, "decode_jump");
            K_JAL, K_JALR:
                add(ins, rb(), rb(), rb(), ev(3'd1, 1'b0, B_PCWR | B_REGWR,
                    (k == K_JAL) ? 3'b010 : 3'b011, 2'b10, 2'b10, 1'b0, 2'b11),
                    dcare | M_PCSRC | M_RD | M_M2R, "decode_link");
            default:
                add(ins, rb(), rb(), rb(), ev(3'd1, 1'b0, B_NONE, 3'b000, 2'b00, 2'b00, 1'b0,
                    2'b11), dcare, "decode");
        endcase
        case (k)
            K_BR:
                add(ins, rb(), rb(), rb(), ev(3'd2, 1'b0, B_PCWC, 3'b001, 2'b00, 2'b00, 1'b1,
                    2'b00), M_BASE | M_PCSRC | M_ASA | M_ASB, "exec_branch");
            K_RALU: begin
                add(ins, rb(), rb(), rb(), ev(3'd2, 1'b0, B_NONE, 3'b000, 2'b00, 2'b00, 1'b1,
                    2'b00), M_BASE | M_ASA | M_ASB, "exec_r");
                plan_wb(ins, 2'b00, 2'b00);
            end
            K_IALU: begin
                add(ins, rb(), rb(), rb(), ev(3'd2, 1'b0, B_NONE, 3'b000, 2'b00, 2'b00, 1'b0,
                    2'b10), M_BASE | M_ASB, "exec_i");
                plan_wb(ins, 2'b01, 2'b00);
            end
            K_LW, K_SW: begin
                add(ins, rb(), rb(), rb(), ev(3'd2, 1'b0, B_NONE, 3'b000, 2'b00, 2'b00, 1'b1,
                    2'b10), M_BASE | M_ASA | M_ASB, "exec_mem");
                plan_access(ins, 1'b0, k == K_LW, wm, rb(), rb(), ok);
                if (ok && k == K_LW) plan_wb(ins, 2'b01, 2'b01);
            end
            default: ;
        endcase
    endtask

    // Drives each planned cycle right after a rising edge and queues its expectation.
    task automatic run_plan();
        rec_t r;
        chk_t c;
        while (plan.size() > 0) begin
            r = plan.pop_front();
            bus.instruction = r.instr;
            bus.mem_ready   = r.rdy;
            bus.irq         = r.irq;
            bus.kernel      = r.kern;
            c.exp = r.exp; c.care = r.care; c.tag = r.tag;
            sb.push_back(c);
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] ins = $urandom;
        logic [11:0] e;
        if ($urandom_range(0, 7) == 0) begin
            for (int t = 0; t < 64 && klass(ins) != K_ILL; t++) ins = $urandom;
            if (klass(ins) != K_ILL) ins = 32'hFC00_0000;
        end else begin
            e = legal[$urandom_range(0, 28)];
            ins[31:26] = e[11:6];
            if (e[11:6] == 6'h00) ins[5:0] = e[5:0];
        end
        return ins;
    endfunction

    function automatic int pick_wait();
        int r = int'($urandom_range(0, 15));
        if (r == 0) return WAIT_MAX;
        if (r == 1) return WAIT_MAX + 1 + int'($urandom_range(0, 3));
        return int'($urandom_range(0, 3));
    endfunction

    // Monitor: compares every cycle for which an expectation was queued.
    initial begin
        chk_t c;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                c = sb.pop_front();
                check(c.tag, pack_out(), c.exp, c.care);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        bus.instruction = 32'hAC00_0000;
        bus.mem_ready   = 1'b1;
        bus.irq         = 1'b1;
        bus.kernel      = 1'b0;
        #2;
        check("reset_init", pack_out(), 20'h0, M_ALL);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        plan_instr(32'h0022_1820, 1'b0, 1'b0, 0, 0);            // add $3,$1,$2
        plan_instr(32'h8FA8_0004, 1'b0, 1'b0, 0, 3);            // lw, 3-cycle wait
        plan_instr(32'h0C00_0010, 1'b0, 1'b0, 0, 0);            // jal
        plan_instr(32'h0022_1820, 1'b1, 1'b0, 0, 0);            // irq trap
        plan_instr(32'h0022_1820, 1'b1, 1'b1, 0, 0);            // irq masked by kernel
        plan_instr(32'h0022_1820, 1'b0, 1'b0, WAIT_MAX + 1, 0); // fetch timeout
        plan_instr(32'h0022_1820, 1'b0, 1'b0, WAIT_MAX, 0);     // completes on last cycle
        plan_instr(32'hAFA8_0004, 1'b0, 1'b0, 0, WAIT_MAX + 1); // sw timeout
        plan_instr(32'h0000_0008, 1'b0, 1'b0, 1, 0);            // jr
        run_plan();

        // sw stalled in MEM, then reset pulled mid-access
        plan_access(32'hAFA8_0004, 1'b1, 1'b0, 0, 1'b0, 1'b0, ok);
        add(32'hAFA8_0004, 1'b1, 1'b0, 1'b0, ev(3'd1, 1'b0, B_NONE, 3'b000, 2'b00, 2'b00,
            1'b0, 2'b11), M_BASE | M_ASA | M_ASB, "rst_decode");
        add(32'hAFA8_0004, 1'b1, 1'b0, 1'b0, ev(3'd2, 1'b0, B_NONE, 3'b000, 2'b00, 2'b00,
            1'b1, 2'b10), M_BASE | M_ASA | M_ASB, "rst_exec");
        add(32'hAFA8_0004, 1'b0, 1'b0, 1'b0, ev(3'd3, 1'b1, B_MEMWR, 3'b000, 2'b00, 2'b00,
            1'b0, 2'b00), M_BASE | M_IORD, "rst_mem");
        run_plan();
        check("mem_before_reset", pack_out(),
              ev(3'd3, 1'b1, B_MEMWR, 3'b000, 2'b00, 2'b00, 1'b0, 2'b00), M_BASE | M_IORD);
        #2;
        reset = 1'b0;
        #1;
        check("reset_async", pack_out(), 20'h0, M_ALL);
        @(posedge clk);
        #1;
        check("reset_hold", pack_out(), 20'h0, M_ALL);
        reset = 1'b1;
        plan_instr(32'hFC00_0000, 1'b0, 1'b0, 0, 0);            // opcode 0x3F
        run_plan();

        for (int n = 0; n < 150; n++) begin
            plan_instr(gen_instr(), $urandom_range(0, 4) == 0, rb(), pick_wait(), pick_wait());
            run_plan();
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
